parity_arbiter: RTL
===================

Name: parity_arbiter

Overview:
- Shares one serial parity engine among NREQ requesters, each presenting an AW-bit address word.
- A round-robin arbiter grants one requester at a time. The word is latched and reduced BW bits per cycle to a single parity bit.
- The result is returned with a one-cycle ack pulse to the granted requester.
- Sits between address generators and the error-check logic, replacing per-requester parity calculators.

Parameters:
- NREQ, 4, number of requesters.
- IDW, 2, width of grant index; must satisfy 2**IDW >= NREQ.
- AW, 32, address word width.
- BW, 8, bits reduced per CALC cycle; AW must be a multiple of BW.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; bit i belongs to requester i.
- addr_bus  input  NREQ*AW  flattened words; requester i uses bits [i*AW +: AW].
- odd_sel  input  1  0 = even parity (XOR of bits), 1 = odd parity (inverted XOR); sampled at grant.
- ack  output  NREQ  one-hot, one-cycle completion pulse to the granted requester.
- parity_out  output  1  result; valid while ack is nonzero, holds its value otherwise.
- gnt_id  output  IDW  index of the current or last granted requester.
- busy  output  1  high while a word is in progress (CALC or DONE).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; ack=0, parity_out=0, gnt_id=0, busy=0.
  - rr_ptr=0, shift register=0, accumulator=0, chunk count=0.
  - An in-flight operation is abandoned and no ack is issued.
- All outputs are registered.
- States: IDLE, CALC, DONE.
- IDLE:
  - If any req is high, grant the first requester with req high, searching from rr_ptr upward with wrap modulo NREQ.
  - On that edge: gnt_id=winner, shift=addr_bus slice of winner, latched odd_sel captured, acc=0, count=0, busy=1, state=CALC.
  - If no req is high, stay in IDLE.
- CALC:
  - Each edge: acc ^= XOR-reduce(shift[BW-1:0]); shift >>= BW; count++.
  - After AW/BW edges (4 by default), on the final edge: parity_out = acc_final ^ latched odd_sel, ack[gnt_id]=1, state=DONE.
- DONE:
  - On the next edge: ack=0, busy=0, rr_ptr=(gnt_id+1) mod NREQ, state=IDLE.
- Latency: req sampled at edge E0; ack high for the cycle after E(AW/BW) (E4 by default). Minimum request-to-request spacing is AW/BW+2 edges (6 by default).
- Requester protocol:
  - Hold req until ack is seen.
  - Deassert req on the edge following the ack cycle; the DONE->IDLE transition guarantees no regrant on that edge.
  - addr_bus and odd_sel changes after grant are ignored (values are latched).
  - A req dropped mid-CALC does not abort; ack still pulses.
- Fairness: a continuously requesting set is served in ascending cyclic order starting from rr_ptr. No requester waits more than NREQ-1 services.
- gnt_id retains its last value in IDLE.
- Reset during DONE: the ack pulse is cut immediately, since reset is asynchronous.
- Width rules:
  - The accumulator is 1 bit.
  - The shift register is AW bits, zero-filled from the MSB.
  - The count register is wide enough for AW/BW.

Test Plan:
- Single requester: req[0]=1, addr=32'd1, odd_sel=0 from reset -> ack=4'b0001 for the cycle after the 4th CALC edge (5th edge after sampling), parity_out=1, gnt_id=0.
- Value sweep on requester 1:
  - Addresses 102, 105, 1032, 157985, each with odd_sel=0 -> parity_out 0, 0, 0, 1.
  - Repeat with odd_sel=1 -> parity_out 1, 1, 1, 0.
- Simultaneous req[0] and req[2] after reset: grant 0 first; the next grant is 2 even if req[0] re-asserts; acks 4'b0001 then 4'b0100, 6 edges apart.
- All four requesting continuously, re-asserting after each ack -> grant order 0,1,2,3,0,1; exactly one ack bit set per service; busy low for exactly one cycle between services.
- Assert reset 2 edges into CALC for requester 3 -> ack never pulses; all outputs 0; after reset release with req[1] high, grant goes to 1 (rr_ptr=0 path).
- After grant, change addr_bus slice and odd_sel mid-CALC -> parity_out reflects the values latched at grant only.

Source files
------------

// File: rtl/parity_arbiter.sv
// -----------------------------------------------------------------------------
// parity_arbiter
//
// Shares one serial parity engine among NREQ requesters. A round-robin
// arbiter picks one requester, its AW-bit address word is latched, and the
// word is folded BW bits per cycle into a single parity bit. The result is
// returned with a one-cycle ack pulse to the granted requester.
//
// Ports
//   clock       in   1         rising-edge clock
//   reset       in   1         asynchronous, active-high reset
//   req         in   NREQ      per-requester request (bit i = requester i)
//   addr_bus    in   NREQ*AW   flattened words, requester i at [i*AW +: AW]
//   odd_sel     in   1         0 = even parity, 1 = odd parity; sampled at grant
//   ack         out  NREQ      one-hot, one-cycle completion pulse
//   parity_out  out  1         result; valid while ack is nonzero, held otherwise
//   gnt_id      out  IDW       index of the current or last granted requester
//   busy        out  1         high while a word is in progress (CALC or DONE)
//
// State table
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for a request; arbitrate and latch word on any req
//   S_CALC | fold BW bits per edge; last chunk writes result and ack
//   S_DONE | ack visible for this cycle; advance round-robin pointer
// -----------------------------------------------------------------------------
module parity_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int AW   = 32,
    parameter int BW   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr_bus,
    input  logic                 odd_sel,
    output logic [NREQ-1:0]      ack,
    output logic                 parity_out,
    output logic [IDW-1:0]       gnt_id,
    output logic                 busy
);

    localparam int NCHUNK = AW / BW;
    localparam int CW     = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    gnt_id_q, gnt_id_d;
    logic [AW-1:0]     shift_q, shift_d;
    logic              acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              odd_q, odd_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              parity_q, parity_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [IDW-1:0]    win_id;
    logic [AW-1:0]     win_word;
    logic              chunk_par;

    // Round-robin search: first requester with req high, starting at rr_ptr
    // and wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign win_word  = addr_bus[win_id*AW +: AW];
    assign chunk_par = ^shift_q[BW-1:0];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        odd_d    = odd_q;
        ack_d    = '0;
        parity_d = parity_q;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_id_d = win_id;
                    shift_d  = win_word;
                    odd_d    = odd_sel;
                    acc_d    = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d   = acc_q ^ chunk_par;
                shift_d = shift_q >> BW;
                cnt_d   = cnt_q + CW'(1);
                // The last chunk is folded straight into the result so the
                // ack appears the cycle after the final CALC edge.
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    parity_d        = acc_q ^ chunk_par ^ odd_q;
                    ack_d[gnt_id_q] = 1'b1;
                    state_d         = S_DONE;
                end
            end
            S_DONE: begin
                busy_d   = 1'b0;
                rr_ptr_d = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
            shift_q  <= '0;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            odd_q    <= 1'b0;
            ack_q    <= '0;
            parity_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            odd_q    <= odd_d;
            ack_q    <= ack_d;
            parity_q <= parity_d;
            busy_q   <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign parity_out = parity_q;
    assign gnt_id     = gnt_id_q;
    assign busy       = busy_q;

endmodule
